// File: rtl/inst_fetch.sv
// inst_fetch: sCPU fetch stage holding the PC, one outstanding imem read at a time,
// a registered instruction presented with valid/ready, and branch redirect squashing.
module inst_fetch #(
  parameter int              PC_W     = 8,
  parameter int              INST_W   = 8,
  parameter logic [PC_W-1:0] RESET_PC = '0
) (
  input  logic              clk,
  input  logic              rst_n,
  output logic              imem_req,
  output logic [PC_W-1:0]   imem_addr,
  input  logic              imem_rvalid,
  input  logic [INST_W-1:0] imem_rdata,
  output logic              if_valid,
  output logic [INST_W-1:0] if_inst,
  output logic [PC_W-1:0]   if_pc,
  output logic [1:0]        if_op,
  input  logic              id_ready,
  input  logic              br_taken,
  input  logic [PC_W-1:0]   br_target
);
  typedef enum logic [1:0] {IDLE, FETCH, WAIT, HOLD} state_t;
  state_t            r_state;
  logic [PC_W-1:0]   r_pc;
  logic [PC_W-1:0]   r_if_pc;
  logic [INST_W-1:0] r_if_inst;
  logic              r_kill;
  logic              r_if_valid;
  // HOLD re-fetches in the consume cycle unless a redirect squashes the held instruction
  assign imem_req  = r_state == FETCH || (r_state == HOLD && id_ready && !br_taken);
  assign imem_addr = r_pc;
  assign if_valid  = r_if_valid;
  assign if_inst   = r_if_inst;
  assign if_pc     = r_if_pc;
  assign if_op     = r_if_inst[INST_W-1 -: 2];
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state    <= IDLE;
      r_pc       <= RESET_PC;
      r_kill     <= 1'b0;
      r_if_valid <= 1'b0;
      r_if_inst  <= '0;
      r_if_pc    <= '0;
    end else begin
      case (r_state)
        IDLE: r_state <= FETCH;
        FETCH: begin
          r_state <= WAIT;
          if (br_taken) begin
            r_pc   <= br_target;
            r_kill <= 1'b1;
          end
        end
        WAIT: begin
          if (br_taken) begin
            r_pc   <= br_target;
            r_kill <= !imem_rvalid;
            if (imem_rvalid) r_state <= FETCH;
          end else if (imem_rvalid && r_kill) begin
            r_kill  <= 1'b0;
            r_state <= FETCH;
          end else if (imem_rvalid) begin
            r_if_inst  <= imem_rdata;
            r_if_pc    <= r_pc;
            r_if_valid <= 1'b1;
            r_pc       <= r_pc + {{(PC_W-1){1'b0}}, 1'b1};
            r_state    <= HOLD;
          end
        end
        HOLD: begin
          if (br_taken) begin
            r_pc       <= br_target;
            r_if_valid <= 1'b0;
            r_state    <= FETCH;
          end else if (id_ready) begin
            r_if_valid <= 1'b0;
            r_state    <= WAIT;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_inst_fetch.sv
// tb_inst_fetch: drives inst_fetch against a variable-latency memory model and
// scoreboards every consumed instruction against expectations queued by the stimulus.
module tb_inst_fetch;
  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       imem_req, imem_rvalid = 1'b0;
  logic [7:0] imem_addr, imem_rdata = 8'h0;
  logic       if_valid, id_ready = 1'b0, br_taken = 1'b0;
  logic [7:0] if_inst, if_pc, br_target = 8'h0;
  logic [1:0] if_op;

  inst_fetch dut (
    .clk(clk), .rst_n(rst_n), .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata), .if_valid(if_valid),
    .if_inst(if_inst), .if_pc(if_pc), .if_op(if_op), .id_ready(id_ready),
    .br_taken(br_taken), .br_target(br_target)
  );

  always #5 clk = ~clk;

  typedef struct {logic [7:0] pc; logic [7:0] inst;} exp_t;
  exp_t q[$];
  logic [7:0] mem[256];
  int lat = 1, cy = 0, n_tot = 0, n_bad = 0, hs_prev = -1, due = 0, s_cy = 0;
  bit per_chk = 0, pend = 0;
  logic [7:0] paddr = 8'h0, s_addr, s_inst, s_pc;
  logic s_req, s_valid;
  logic [1:0] s_op;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tot++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0h exp=%0h (cycle %0d)", tag, got, exp, cy);
    end
  endtask

  // One clock: sample, scoreboard handshakes, record requests, then memory responds after the edge
  task automatic cyc();
    #1;
    s_req = imem_req; s_addr = imem_addr; s_valid = if_valid;
    s_inst = if_inst; s_pc = if_pc; s_op = if_op; s_cy = cy;
    if (rst_n && if_valid && id_ready && !br_taken) begin
      if (q.size() == 0) check("unexp_hs", 1, 0);
      else begin
        exp_t e = q.pop_front();
        check("hs_pc", if_pc, e.pc);
        check("hs_inst", if_inst, e.inst);
        check("hs_op", if_op, e.inst[7:6]);
      end
      if (per_chk && hs_prev >= 0) check("period", cy - hs_prev, 2);
      hs_prev = cy;
    end
    if (rst_n && imem_req) begin
      if (pend) check("overlap", 1, 0);
      pend = 1; paddr = imem_addr; due = cy + lat;
    end
    @(posedge clk);
    #1;
    cy++;
    br_taken = 1'b0;
    if (!rst_n) pend = 0;
    imem_rvalid = pend && due == cy;
    imem_rdata = imem_rvalid ? mem[paddr] : 8'hEE;
    if (imem_rvalid) pend = 0;
  endtask

  task automatic wait_req(output logic [7:0] a, output int c);
    bit done = 0;
    a = 8'h0; c = -1;
    for (int i = 0; i < 40 && !done; i++) begin
      cyc();
      if (s_req) begin a = s_addr; c = s_cy; done = 1; end
    end
    if (!done) check("req_timeout", 0, 1);
  endtask

  task automatic wait_valid();
    bit done = 0;
    for (int i = 0; i < 40 && !done; i++) begin
      cyc();
      done = s_valid;
    end
    if (!done) check("valid_timeout", 0, 1);
  endtask

  task automatic drain();
    for (int i = 0; i < 60 && q.size() > 0; i++) cyc();
    check("drain_left", q.size(), 0);
  endtask

  task automatic check_rst();
    #1;
    check("rst_req", imem_req, 0);
    check("rst_addr", imem_addr, 8'h00);
    check("rst_valid", if_valid, 0);
    check("rst_inst", if_inst, 8'h00);
    check("rst_pc", if_pc, 8'h00);
    check("rst_op", if_op, 2'b00);
  endtask

  initial begin
    logic [7:0] a;
    int c, rvc, nval;
    for (int i = 0; i < 256; i++) mem[i] = 8'(i);
    rst_n = 1'b0;
    cyc(); cyc();
    check_rst();
    // Straight-line fetch, latency 1, always ready
    rst_n = 1'b1; cy = 1; id_ready = 1'b1; per_chk = 1;
    q.push_back('{8'h00, 8'h00}); q.push_back('{8'h01, 8'h01}); q.push_back('{8'h02, 8'h02});
    wait_req(a, c);
    check("first_req_cycle", c, 2);
    check("first_req_addr", a, 8'h00);
    drain();
    per_chk = 0;
    // Stall while holding 0x85 at 0x10, latency 3
    lat = 3; id_ready = 1'b0; mem[8'h10] = 8'h85;
    wait_valid();
    br_taken = 1'b1; br_target = 8'h10;
    cyc();
    check("hold_br_noreq", s_req, 0);
    wait_valid();
    for (int i = 0; i < 4; i++) begin
      cyc();
      check("stall_valid", s_valid, 1);
      check("stall_inst", s_inst, 8'h85);
      check("stall_pc", s_pc, 8'h10);
      check("stall_op", s_op, 2'b10);
      check("stall_noreq", s_req, 0);
    end
    q.push_back('{8'h10, 8'h85});
    id_ready = 1'b1;
    cyc();
    check("ready_req", s_req, 1);
    check("ready_addr", s_addr, 8'h11);
    check("sb_empty", q.size(), 0);
    // Redirect in the first WAIT cycle: stale response must be dropped
    br_taken = 1'b1; br_target = 8'h40;
    cyc();
    nval = s_valid; rvc = -1;
    for (int i = 0; i < 20 && !s_req; i++) begin
      if (imem_rvalid) rvc = cy;
      cyc();
      nval += int'(s_valid);
    end
    check("wait_br_addr", s_addr, 8'h40);
    check("wait_br_cycle", s_cy, rvc + 1);
    check("wait_br_novalid", nval, 0);
    q.push_back('{8'h40, 8'h40});
    drain();
    // Redirect in the same cycle as the response
    for (int i = 0; i < 20 && !imem_rvalid; i++) cyc();
    check("rv_seen", imem_rvalid, 1);
    br_taken = 1'b1; br_target = 8'h60;
    cyc();
    check("rvbr_novalid0", s_valid, 0);
    cyc();
    check("rvbr_novalid1", s_valid, 0);
    check("rvbr_req", s_req, 1);
    check("rvbr_addr", s_addr, 8'h60);
    q.push_back('{8'h60, 8'h60});
    drain();
    // Redirect in HOLD while decode is ready: held instruction squashed, not consumed
    id_ready = 1'b0;
    wait_valid();
    id_ready = 1'b1; br_taken = 1'b1; br_target = 8'h80;
    cyc();
    check("holdbr_noreq", s_req, 0);
    cyc();
    check("holdbr_valid", s_valid, 0);
    check("holdbr_req", s_req, 1);
    check("holdbr_addr", s_addr, 8'h80);
    q.push_back('{8'h80, 8'h80});
    drain();
    // PC wrap from 0xFF to 0x00
    id_ready = 1'b0;
    wait_valid();
    lat = 1; br_taken = 1'b1; br_target = 8'hFF;
    cyc();
    q.push_back('{8'hFF, 8'hFF}); q.push_back('{8'h00, 8'h00});
    id_ready = 1'b1;
    wait_req(a, c);
    check("wrap_addr_ff", a, 8'hFF);
    wait_req(a, c);
    check("wrap_addr_00", a, 8'h00);
    drain();
    // Reset during WAIT abandons everything
    check("pre_rst_pend_or_rv", pend || imem_rvalid, 1);
    rst_n = 1'b0;
    cyc();
    check_rst();
    q.delete();
    rst_n = 1'b1; cy = 1;
    wait_req(a, c);
    check("rerst_req_cycle", c, 2);
    check("rerst_req_addr", a, 8'h00);
    q.push_back('{8'h00, 8'h00});
    drain();
    $display("test done: total=%0d bad=%0d", n_tot, n_bad);
    $finish;
  end
endmodule
